// File: rtl/ndn_spi_packet_receiver.sv
// ndn_spi_packet_receiver
//  Slave-side deserializer for the NDN SPI packet stream. mosi is sampled on
//  every clk edge, framed as start bit / meta / prefix / tail / end bit, and
//  each completed byte is queued in an output FIFO. The FIFO feeds a
//  valid/ready byte stream with SOF/EOF markers.
//  Optional build macro RX_STATS_EN adds saturating packet/error counters.
module ndn_spi_packet_receiver #(
    parameter int PREFIX_BYTES = 8,
    parameter int LMP_BYTES    = 8,
    parameter int DATA_BYTES   = 32,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        mosi,
    output logic [7:0]  out_byte,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_is_interest,
    output logic        frame_err,
    output logic        overflow,
    input  logic        ovf_clr
`ifdef RX_STATS_EN
    ,
    output logic [15:0] stat_interest,
    output logic [15:0] stat_data,
    output logic [15:0] stat_err
`endif
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int MAXB0 = (PREFIX_BYTES > LMP_BYTES) ? PREFIX_BYTES : LMP_BYTES;
    localparam int MAXB  = (MAXB0 > DATA_BYTES) ? MAXB0 : DATA_BYTES;
    localparam int CW    = $clog2(MAXB) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_META   = 3'd1;
    localparam logic [2:0] S_PREFIX = 3'd2;
    localparam logic [2:0] S_TAIL   = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    logic [2:0]    state;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] byte_cnt;
    logic [6:0]    shreg;

    logic [7:0]    byte_now;
    logic          in_byte_state;
    logic          busy;
    logic          abort;
    logic          last_bit;

    // push stage: byte completing on this edge, with its markers
    logic          vld_p0;
    logic [9:0]    ent_p0;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          drop;
    logic [9:0]    head;

    // Framing decode: current bit completes a byte when the bit counter reaches 0
    always_comb begin
        byte_now      = {shreg, mosi};
        in_byte_state = (state == S_META) || (state == S_PREFIX) || (state == S_TAIL);
        busy          = in_byte_state || (state == S_STOP);
        abort         = busy && cs;
        last_bit      = (bit_cnt == 3'd0);
        vld_p0        = in_byte_state && !cs && last_bit;
        ent_p0        = {(state == S_META),
                         (state == S_TAIL) && (byte_cnt == '0),
                         byte_now};
    end

    // Serial shift register; holds the 7 most recent bits of the byte in flight
    always_ff @(posedge clk) begin
        shreg <= byte_now[6:0];
    end

    // Packet framing FSM: field sequencing, abort on cs, end-bit check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            bit_cnt         <= 3'd7;
            byte_cnt        <= '0;
            frame_err       <= 1'b0;
            out_is_interest <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (abort) begin
                frame_err <= 1'b1;
                state     <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!cs && !mosi) begin
                            state   <= S_META;
                            bit_cnt <= 3'd7;
                        end
                    end
                    S_META, S_PREFIX, S_TAIL: begin
                        bit_cnt <= bit_cnt - 3'd1;
                        if (last_bit) begin
                            case (state)
                                S_META: begin
                                    out_is_interest <= byte_now[6];
                                    byte_cnt        <= CW'(PREFIX_BYTES - 1);
                                    state           <= S_PREFIX;
                                end
                                S_PREFIX: begin
                                    if (byte_cnt == '0) begin
                                        byte_cnt <= out_is_interest ? CW'(LMP_BYTES - 1)
                                                                    : CW'(DATA_BYTES - 1);
                                        state    <= S_TAIL;
                                    end else begin
                                        byte_cnt <= byte_cnt - 1'b1;
                                    end
                                end
                                default: begin
                                    if (byte_cnt == '0) begin
                                        state <= S_STOP;
                                    end else begin
                                        byte_cnt <= byte_cnt - 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                    S_STOP: begin
                        // end bit must be low; GAP then waits for mosi high so
                        // this low bit is never mistaken for a start bit
                        frame_err <= mosi;
                        state     <= S_GAP;
                    end
                    S_GAP: begin
                        if (mosi) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // FIFO status; a pop frees a slot for a push on the same edge
    always_comb begin
        empty = (wptr == rptr);
        full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        pop   = !empty && out_ready;
        wr_en = vld_p0 && (!full || pop);
        drop  = vld_p0 && full && !pop;
        head  = mem[rptr[AW-1:0]];
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= ent_p0;
        end
    end

    // FIFO pointers and sticky overflow flag (a new drop wins over ovf_clr)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Output stream; zeroed while empty so stale storage never shows
    always_comb begin
        out_valid = !empty;
        out_sof   = !empty && head[9];
        out_eof   = !empty && head[8];
        out_byte  = empty ? 8'h00 : head[7:0];
    end

`ifdef RX_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Packet and error statistics, saturating at 16'hFFFF
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_interest <= '0;
            stat_data     <= '0;
            stat_err      <= '0;
        end else begin
            if (vld_p0 && ent_p0[8]) begin
                if (out_is_interest) begin
                    stat_interest <= sat_inc(stat_interest);
                end else begin
                    stat_data <= sat_inc(stat_data);
                end
            end
            if (frame_err) begin
                stat_err <= sat_inc(stat_err);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ndn_spi_packet_receiver.sv
// tb_ndn_spi_packet_receiver
//  Directed and randomized packets driven bit by bit; the expected byte
//  stream comes from packet contents kept as byte queues, with a simple
//  queue-based FIFO occupancy model for backpressure and overflow.
module tb_ndn_spi_packet_receiver;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        mosi;
    logic [7:0]  out_byte;
    logic        out_sof;
    logic        out_eof;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_interest;
    logic        frame_err;
    logic        overflow;
    logic        ovf_clr;
`ifdef RX_STATS_EN
    logic [15:0] stat_interest;
    logic [15:0] stat_data;
    logic [15:0] stat_err;
`endif

    always #5 clk = ~clk;

    ndn_spi_packet_receiver #(
        .PREFIX_BYTES(8), .LMP_BYTES(8), .DATA_BYTES(32), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .cs(cs), .mosi(mosi),
        .out_byte(out_byte), .out_sof(out_sof), .out_eof(out_eof),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_is_interest(out_is_interest), .frame_err(frame_err),
        .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef RX_STATS_EN
        , .stat_interest(stat_interest), .stat_data(stat_data), .stat_err(stat_err)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  q[$];        // expected FIFO contents {sof,eof,byte}
    logic        ovf_m = 1'b0;
    logic [7:0]  pkt[$];      // packet under transmission
    int          rdy_mode = 0; // 0 always ready, 1 random, 2 never
    int          clr_byte = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy_gen();
        if (rdy_mode == 0) return 1'b1;
        if (rdy_mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    // One clock: drive at negedge, update model at posedge, check at next negedge
    task automatic step(input logic c, input logic m, input logic rdy, input logic clr,
                        input bit push, input logic [9:0] pv, input logic err);
        bit pop_m;
        cs        = c;
        mosi      = m;
        out_ready = rdy;
        ovf_clr   = clr;
        pop_m     = (q.size() != 0) && rdy;
        @(posedge clk);
        if (pop_m) void'(q.pop_front());
        if (push && q.size() >= DEPTH) ovf_m = 1'b1;
        else begin
            if (push) q.push_back(pv);
            if (clr) ovf_m = 1'b0;
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0)
            chk("head{sof,eof,byte}", 32'({out_sof, out_eof, out_byte}), 32'(q[0]));
        chk("frame_err", 32'(frame_err), 32'(err));
        chk("overflow", 32'(overflow), 32'(ovf_m));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b1, rdy_gen(), 1'b0, 1'b0, 10'h0, 1'b0);
    endtask

    // cut_kind: 0 none, 1 raise cs before byte cut_at, 2 stop driving before byte cut_at
    task automatic send_pkt(input logic endb, input int gap_low, input int cut_at, input int cut_kind);
        step(1'b0, 1'b0, rdy_gen(), 1'b0, 1'b0, 10'h0, 1'b0);
        for (int i = 0; i < pkt.size(); i++) begin
            if (cut_kind != 0 && i == cut_at) begin
                if (cut_kind == 1) step(1'b1, 1'b1, rdy_gen(), 1'b0, 1'b0, 10'h0, 1'b1);
                return;
            end
            for (int b = 7; b >= 0; b--) begin
                step(1'b0, pkt[i][b], rdy_gen(), 1'((b == 0) && (i == clr_byte)),
                     (b == 0), {(i == 0), (i == pkt.size() - 1), pkt[i]}, 1'b0);
            end
        end
        step(1'b0, endb, rdy_gen(), 1'b0, 1'b0, 10'h0, endb);
        for (int k = 0; k < gap_low; k++) step(1'b0, 1'b0, rdy_gen(), 1'b0, 1'b0, 10'h0, 1'b0);
        step(1'b0, 1'b1, rdy_gen(), 1'b0, 1'b0, 10'h0, 1'b0);
        chk("out_is_interest", 32'(out_is_interest), 32'(pkt[0][6]));
    endtask

    task automatic make_rand(input bit interest);
        pkt.delete();
        pkt.push_back({1'($urandom), interest, 6'($urandom)});
        for (int k = 0; k < 8 + (interest ? 8 : 32); k++) pkt.push_back(8'($urandom));
    endtask

    task automatic drain();
        int save = rdy_mode;
        rdy_mode = 0;
        idle(DEPTH + 2);
        rdy_mode = save;
    endtask

    initial begin
        logic [63:0] pre;
        logic [63:0] lmp;
        rst = 1'b0; cs = 1'b1; mosi = 1'b1; out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_byte", 32'(out_byte), 32'd0);
        chk("reset sof/eof", 32'({out_sof, out_eof}), 32'd0);
        chk("reset is_interest", 32'(out_is_interest), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        idle(3);

        // directed interest packet
        pre = 64'h0123456789ABCDEF;
        lmp = 64'hFEDCBA9876543210;
        pkt.delete();
        pkt.push_back(8'h48);
        for (int k = 7; k >= 0; k--) pkt.push_back(pre[k*8 +: 8]);
        for (int k = 7; k >= 0; k--) pkt.push_back(lmp[k*8 +: 8]);
        rdy_mode = 1;
        send_pkt(1'b0, 0, 0, 0);
        drain();

        // directed data packet, payload 00..1F, always ready
        rdy_mode = 0;
        pkt.delete();
        pkt.push_back(8'h08);
        for (int k = 0; k < 8; k++) pkt.push_back(8'(8'hA0 + k));
        for (int k = 0; k < 32; k++) pkt.push_back(8'(k));
        send_pkt(1'b0, 0, 0, 0);
        drain();

        // bad end bit, then low cycles in the gap must not restart framing
        make_rand(1'b1);
        send_pkt(1'b1, 0, 0, 0);
        make_rand(1'b0);
        send_pkt(1'b0, 3, 0, 0);
        drain();

        // overflow: no consumer, a clear coinciding with a drop keeps it set
        rdy_mode = 2;
        make_rand(1'b0);
        clr_byte = 30;
        send_pkt(1'b0, 0, 0, 0);
        clr_byte = -1;
        idle(2);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h0, 1'b0);
        idle(2);
        drain();

        // cs abort after meta + 3 prefix bytes, then a clean packet
        rdy_mode = 2;
        make_rand(1'b1);
        send_pkt(1'b0, 0, 4, 1);
        idle(3);
        rdy_mode = 1;
        make_rand(1'b1);
        send_pkt(1'b0, 0, 0, 0);
        drain();

        // back-to-back interest packets with one idle-high cycle between
        make_rand(1'b1);
        send_pkt(1'b0, 0, 0, 0);
        make_rand(1'b1);
        send_pkt(1'b0, 0, 0, 0);
        drain();

        // reset mid-packet flushes everything
        rdy_mode = 2;
        make_rand(1'b0);
        send_pkt(1'b0, 0, 6, 2);
        rst = 1'b0;
        #1;
        q.delete();
        ovf_m = 1'b0;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset is_interest", 32'(out_is_interest), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // randomized packets, random backpressure, occasional bad end bit
        rdy_mode = 1;
        for (int n = 0; n < 8; n++) begin
            make_rand(1'($urandom));
            send_pkt(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), 0, 0);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
